atm_authenticator: RTL and testbench
====================================

# atm_authenticator

Synchronous ATM account core: checks an account number and PIN against an internal 10-entry account database, then runs a registered menu state machine for balance inquiry, withdrawal, deposit and PIN change on the authenticated account. It sits between the user-input front end (keypad/card decode) and any display/receipt logic, and owns both the PIN and balance databases.

## Interface
Parameters:
- NUM_ACCOUNTS, 10: number of accounts; valid account numbers 0..NUM_ACCOUNTS-1.
- INIT_BALANCE, 500: reset balance of every account (32-bit).
- INIT_PIN_BASE, 1234: reset PIN of account i is INIT_PIN_BASE+i (16-bit).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- operation  in  3  menu selection: 1 balance, 2 withdraw, 3 deposit, 4 change PIN, 5 exit; other values are ignored.
- acc_num  in  4  account number.
- pin  in  16  entered PIN.
- new_pin  in  16  replacement PIN for change-PIN.
- amount  in  32  unsigned withdraw/deposit amount.
- language  in  1  0 English, 1 Arabic; affects messages only.
- current_state  out  3  FSM state code.
- balance  out  32  balance of the session account; 0 outside a session.
- acc_found  out  1  combinational: acc_num < NUM_ACCOUNTS.
- acc_auth  out  1  combinational: acc_found and pin equals stored PIN of acc_num.
- op_status  out  2  0 none, 1 ok, 2 rejected (funds/overflow).

## Operation
- States: WAITING=0, MENU=1, BALANCE=2, WITHDRAW=3, DEPOSIT=4, CHANGE_PIN=5.
- WAITING: when acc_auth=1, go to MENU and latch acc_num as the session index (sess_idx). Otherwise stay.
- MENU: operation 1/2/3/4 selects BALANCE/WITHDRAW/DEPOSIT/CHANGE_PIN. Operation 5 selects WAITING. Any other value stays in MENU.
- Every action state lasts exactly one cycle and then returns to MENU. The action commits on the edge that leaves the state.
  - BALANCE: no database change; op_status<=1.
  - WITHDRAW: if amount <= bal[sess_idx], then bal <= bal-amount and op_status<=1. Otherwise bal is unchanged and op_status<=2.
  - DEPOSIT: if bal+amount has no 32-bit carry, then bal <= sum and op_status<=1. On carry, bal is unchanged and op_status<=2.
  - CHANGE_PIN: pin_db[sess_idx] <= new_pin; op_status<=1.
- sess_idx is frozen for the session; acc_num/pin changes after login have no effect until the next WAITING.
- balance output is registered: it equals bal[sess_idx] in every non-WAITING state, reflects commits the cycle after, and is 0 in WAITING.
- op_status holds its value until the next action; it clears to 0 on entry to WAITING.
- Undefined current_state codes go to WAITING.

## Timing
- Reset (async assert, sync release) sets:
  - current_state=WAITING, balance=0, op_status=0, sess_idx=0;
  - all balances=INIT_BALANCE and all PINs=INIT_PIN_BASE+i.
- Reset mid-operation aborts the action without committing and restores the databases.
- Latency: login takes 1 edge; menu to action takes 1 edge; action commit and return to MENU take 1 edge; updated balance is visible in MENU.
- acc_found/acc_auth: zero latency, combinational from inputs and the current pin_db. A PIN changed on edge N is used for auth from edge N onward.

## Configuration
- ATM_MSG_EN defined: simulation $display messages in the selected language.
  - Welcome message after reset.
  - Menu listing on each MENU entry.
  - Balance value in BALANCE; result text for each action.
- ATM_MSG_EN undefined: no $display; logic is identical.

## Structure
- Package atm_pkg holds:
  - state codes, operation codes, op_status codes, language codes (ENGLISH=0, ARABIC=1);
  - NUM_ACCOUNTS default.
- Sub-module atm_pin_checker: combinational acc_num/pin compare against the PIN array. It outputs acc_found and acc_auth; the PIN array itself stays in the top.

## Test plan
- Reset, acc_num=3, pin=1237 -> acc_auth=1, MENU next edge; operation=1 -> BALANCE then MENU, balance=500, op_status=1.
- Login account 2 (pin 1236), withdraw 200 -> balance 300, op_status=1; withdraw 400 -> balance 300, op_status=2.
- Deposit 150 into account 0 -> 650; deposit 32'hFFFFFFFF -> unchanged, op_status=2.
- Wrong PIN (acc 5, pin 0) or acc_num=12 -> acc_found/acc_auth per rule, state stays WAITING.
- Change PIN of account 1 to 4321, exit (op 5) -> WAITING. Old pin 1235 gives acc_auth=0; 4321 gives acc_auth=1.
- Assert rst during WITHDRAW -> WAITING; login again shows balance 500.

Source files
------------

// File: rtl/atm_pkg.sv
// atm_pkg: shared state, operation, status and language codes for the ATM core
package atm_pkg;
  localparam int unsigned NUM_ACCOUNTS_DEF = 10;
  typedef enum logic [2:0] {
    S_WAITING    = 3'd0,
    S_MENU       = 3'd1,
    S_BALANCE    = 3'd2,
    S_WITHDRAW   = 3'd3,
    S_DEPOSIT    = 3'd4,
    S_CHANGE_PIN = 3'd5
  } state_t;
  localparam logic [2:0] OP_BALANCE = 3'd1;
  localparam logic [2:0] OP_WITHDRAW = 3'd2;
  localparam logic [2:0] OP_DEPOSIT = 3'd3;
  localparam logic [2:0] OP_CHANGE_PIN = 3'd4;
  localparam logic [2:0] OP_EXIT = 3'd5;
  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_OK   = 2'd1,
    ST_REJ  = 2'd2
  } op_status_t;
  typedef enum logic {
    ENGLISH = 1'b0,
    ARABIC  = 1'b1
  } lang_t;
endpackage

// File: rtl/atm_pin_checker.sv
// atm_pin_checker: combinational account-range and PIN match against the PIN array
module atm_pin_checker
  import atm_pkg::*;
#(
  parameter int unsigned NUM_ACCOUNTS = NUM_ACCOUNTS_DEF
) (
  input  logic [3:0]                    acc_num,
  input  logic [15:0]                   pin,
  input  logic [NUM_ACCOUNTS-1:0][15:0] pin_db,
  output logic                          acc_found,
  output logic                          acc_auth
);
  logic [15:0] w_stored;
  assign acc_found = 32'(acc_num) < NUM_ACCOUNTS;
  assign w_stored = acc_found ? pin_db[acc_num] : '0;
  assign acc_auth = acc_found && pin == w_stored;
endmodule

// File: rtl/atm_authenticator.sv
// atm_authenticator: login and menu FSM over internal PIN/balance databases; define ATM_MSG_EN for simulation messages
module atm_authenticator
  import atm_pkg::*;
#(
  parameter int unsigned NUM_ACCOUNTS = NUM_ACCOUNTS_DEF,
  parameter logic [31:0] INIT_BALANCE = 32'd500,
  parameter logic [15:0] INIT_PIN_BASE = 16'd1234
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  operation,
  input  logic [3:0]  acc_num,
  input  logic [15:0] pin,
  input  logic [15:0] new_pin,
  input  logic [31:0] amount,
  input  logic        language,
  output logic [2:0]  current_state,
  output logic [31:0] balance,
  output logic        acc_found,
  output logic        acc_auth,
  output logic [1:0]  op_status
);
  state_t                        r_state, w_next;
  op_status_t                    r_op, w_status;
  logic [3:0]                    r_sess, w_idx;
  logic [31:0]                   r_balance, w_cur_bal, w_new_bal;
  logic [31:0]                   r_bal [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0][15:0] r_pin_db;
  logic [32:0]                   w_sum;
  logic                          w_wd_ok, w_dep_ok, w_action;

  atm_pin_checker #(.NUM_ACCOUNTS(NUM_ACCOUNTS)) u_chk (
    .acc_num  (acc_num),
    .pin      (pin),
    .pin_db   (r_pin_db),
    .acc_found(acc_found),
    .acc_auth (acc_auth)
  );

  // at login the session index is not latched yet, so read through acc_num
  assign w_idx = r_state == S_WAITING ? acc_num : r_sess;
  assign w_cur_bal = r_bal[w_idx];
  assign w_sum = {1'b0, w_cur_bal} + {1'b0, amount};
  assign w_wd_ok = amount <= w_cur_bal;
  assign w_dep_ok = !w_sum[32];
  assign w_action = r_state inside {S_BALANCE, S_WITHDRAW, S_DEPOSIT, S_CHANGE_PIN};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAITING: w_next = acc_auth ? S_MENU : S_WAITING;
      S_MENU:
        w_next = operation == OP_BALANCE    ? S_BALANCE    :
                 operation == OP_WITHDRAW   ? S_WITHDRAW   :
                 operation == OP_DEPOSIT    ? S_DEPOSIT    :
                 operation == OP_CHANGE_PIN ? S_CHANGE_PIN :
                 operation == OP_EXIT       ? S_WAITING    : S_MENU;
      S_BALANCE, S_WITHDRAW, S_DEPOSIT, S_CHANGE_PIN: w_next = S_MENU;
      default: w_next = S_WAITING;
    endcase
  end

  always_comb begin
    w_new_bal = w_cur_bal;
    w_status = ST_OK;
    if (r_state == S_WITHDRAW) begin
      w_new_bal = w_wd_ok ? w_cur_bal - amount : w_cur_bal;
      w_status = w_wd_ok ? ST_OK : ST_REJ;
    end else if (r_state == S_DEPOSIT) begin
      w_new_bal = w_dep_ok ? w_sum[31:0] : w_cur_bal;
      w_status = w_dep_ok ? ST_OK : ST_REJ;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_WAITING;
      r_op <= ST_NONE;
      r_sess <= '0;
      r_balance <= '0;
      for (int unsigned i = 0; i < NUM_ACCOUNTS; i++) begin
        r_bal[i] <= INIT_BALANCE;
        r_pin_db[i] <= INIT_PIN_BASE + 16'(i);
      end
    end else begin
      r_state <= w_next;
      r_balance <= w_next == S_WAITING ? '0 : w_new_bal;
      r_op <= w_next == S_WAITING ? ST_NONE : w_action ? w_status : r_op;
      if (r_state == S_WAITING && acc_auth) r_sess <= acc_num;
      if (r_state == S_WITHDRAW || r_state == S_DEPOSIT) r_bal[r_sess] <= w_new_bal;
      if (r_state == S_CHANGE_PIN) r_pin_db[r_sess] <= new_pin;
    end
  end

  assign current_state = r_state;
  assign balance = r_balance;
  assign op_status = r_op;

`ifdef ATM_MSG_EN
  logic r_msg_new;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_msg_new <= 1'b1;
    else begin
      r_msg_new <= 1'b0;
      if (r_msg_new) $display("%s", language == ARABIC ? "Ahlan wa sahlan" : "Welcome");
      if (w_next == S_MENU && r_state != S_MENU)
        $display("%s", language == ARABIC ? "1 rased 2 sahb 3 eeda 4 taghyeer 5 khorooj" : "1 balance 2 withdraw 3 deposit 4 change PIN 5 exit");
      if (r_state == S_BALANCE) $display("%s %0d", language == ARABIC ? "Al rased:" : "Balance:", w_cur_bal);
      if (w_action)
        $display("%s", w_status == ST_OK ? (language == ARABIC ? "Tamm" : "Done") : (language == ARABIC ? "Marfood" : "Rejected"));
    end
  end
`else
  logic w_unused_lang;
  assign w_unused_lang = language;
`endif
endmodule

// File: tb/tb_atm_authenticator.sv
// tb_atm_authenticator: directed stimulus with a per-cycle account-level reference model
module tb_atm_authenticator;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  operation = '0;
  logic [3:0]  acc_num = '0;
  logic [15:0] pin = '0;
  logic [15:0] new_pin = '0;
  logic [31:0] amount = '0;
  logic        language = 1'b0;
  logic [2:0]  current_state;
  logic [31:0] balance;
  logic        acc_found, acc_auth;
  logic [1:0]  op_status;

  int errs = 0;
  int checks = 0;

  longint m_bal [10];
  int     m_pin [10];
  int     m_st, m_sess, m_op;

  atm_authenticator dut (
    .clk(clk), .rst(rst), .operation(operation), .acc_num(acc_num), .pin(pin),
    .new_pin(new_pin), .amount(amount), .language(language),
    .current_state(current_state), .balance(balance), .acc_found(acc_found),
    .acc_auth(acc_auth), .op_status(op_status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  function automatic bit m_found();
    return acc_num < 10;
  endfunction

  function automatic bit m_auth();
    return acc_num < 10 && int'(pin) == m_pin[acc_num];
  endfunction

  function automatic longint m_balance();
    return m_st == 0 ? 0 : m_bal[m_sess];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 10; i++) begin
      m_bal[i] = 500;
      m_pin[i] = 1234 + i;
    end
    m_st = 0;
    m_sess = 0;
    m_op = 0;
  endtask

  // one clock edge of account-level behaviour: login, menu choice, or one committed action
  task automatic m_step();
    if (!rst) begin
      m_reset();
      return;
    end
    if (m_st == 0) begin
      if (m_auth()) begin
        m_sess = acc_num;
        m_st = 1;
      end
    end else if (m_st == 1) begin
      if (operation >= 1 && operation <= 4) m_st = operation + 1;
      else if (operation == 5) begin
        m_st = 0;
        m_op = 0;
      end
    end else begin
      if (m_st == 3) begin
        if (amount <= m_bal[m_sess]) begin
          m_bal[m_sess] -= amount;
          m_op = 1;
        end else m_op = 2;
      end else if (m_st == 4) begin
        if (m_bal[m_sess] + amount <= 64'hFFFF_FFFF) begin
          m_bal[m_sess] += amount;
          m_op = 1;
        end else m_op = 2;
      end else begin
        if (m_st == 5) m_pin[m_sess] = new_pin;
        m_op = 1;
      end
      m_st = 1;
    end
  endtask

  always @(negedge clk) begin
    chk("state", current_state, m_st);
    chk("balance", balance, m_balance());
    chk("op_status", op_status, m_op);
    chk("acc_found", acc_found, m_found());
    chk("acc_auth", acc_auth, m_auth());
  end

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic login(input int a, input int p);
    acc_num = 4'(a);
    pin = 16'(p);
    tick();
  endtask

  task automatic do_op(input int op);
    operation = 3'(op);
    tick();
    operation = 3'd0;
    tick();
  endtask

  task automatic logout();
    operation = 3'd5;
    tick();
    operation = 3'd0;
  endtask

  initial begin
    m_reset();
    tick();
    tick();
    rst = 1'b1;
    chk("rst_state", current_state, 0);
    chk("rst_balance", balance, 0);
    chk("rst_op", op_status, 0);

    acc_num = 4'd3;
    pin = 16'd1237;
    #1 chk("auth3", acc_auth, 1);
    tick();
    chk("login3_state", current_state, 1);
    operation = 3'd1;
    tick();
    chk("bal_state", current_state, 2);
    operation = 3'd0;
    tick();
    chk("bal_menu", current_state, 1);
    chk("bal3", balance, 500);
    chk("bal3_op", op_status, 1);
    logout();
    chk("exit_state", current_state, 0);
    chk("exit_op", op_status, 0);
    chk("exit_bal", balance, 0);

    login(2, 1236);
    acc_num = 4'd7;
    amount = 200;
    do_op(2);
    chk("wd200", balance, 300);
    chk("wd200_op", op_status, 1);
    amount = 400;
    do_op(2);
    chk("wd400", balance, 300);
    chk("wd400_op", op_status, 2);
    logout();

    login(0, 1234);
    amount = 150;
    do_op(3);
    chk("dep150", balance, 650);
    amount = 32'hFFFF_FFFF;
    do_op(3);
    chk("dep_ovf", balance, 650);
    chk("dep_ovf_op", op_status, 2);
    amount = 650;
    do_op(2);
    chk("wd_all", balance, 0);
    chk("wd_all_op", op_status, 1);
    amount = 32'hFFFF_FFFF;
    do_op(3);
    chk("dep_max", balance, 32'hFFFF_FFFF);
    logout();

    acc_num = 4'd5;
    pin = 16'd0;
    #1 chk("wrong_found", acc_found, 1);
    chk("wrong_auth", acc_auth, 0);
    tick();
    chk("wrong_state", current_state, 0);
    acc_num = 4'd12;
    pin = 16'd1246;
    #1 chk("oob_found", acc_found, 0);
    chk("oob_auth", acc_auth, 0);
    tick();
    chk("oob_state", current_state, 0);

    login(1, 1235);
    new_pin = 16'd4321;
    do_op(4);
    chk("pin_op", op_status, 1);
    logout();
    acc_num = 4'd1;
    pin = 16'd1235;
    #1 chk("oldpin", acc_auth, 0);
    pin = 16'd4321;
    #1 chk("newpin", acc_auth, 1);

    login(4, 1238);
    amount = 100;
    operation = 3'd2;
    tick();
    chk("mid_wd", current_state, 3);
    operation = 3'd0;
    rst = 1'b0;
    m_reset();
    #1 chk("abort_state", current_state, 0);
    tick();
    rst = 1'b1;
    acc_num = 4'd1;
    pin = 16'd1235;
    #1 chk("pin_restored", acc_auth, 1);
    login(4, 1238);
    chk("relogin_bal", balance, 500);
    logout();
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
